if_stage: RTL and testbench

- Instruction-fetch stage of the pipelined sccpu, sitting directly upstream of decode.
- Holds the PC and drives a combinational-read instruction memory port.
- Selects the next PC from sequential, branch, register-jump or jump targets.
- Registers the fetched word and PC+4 into the IF/ID pipeline register, with stall and flush control from the hazard unit.

---
 rtl/if_stage_if.sv | 39 +++
 rtl/if_stage.sv | 95 +++++++++
 tb/tb_if_stage.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// ============================================================================
//  Module      : if_stage_if
//  Description : Bus bundle between the fetch stage and its neighbours.
//                It carries the hazard-unit controls, the next-PC targets, the
//                instruction-memory port and the IF/ID register outputs.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface if_stage_if;
    logic        stall;
    logic        flush;
    logic [1:0]  pcsrc;
    logic [31:0] bpc;
    logic [31:0] rpc;
    logic [31:0] jpc;
    logic [31:0] imem_data;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic [31:0] dinst;
    logic [31:0] dpc4;
    logic        dvalid;
    logic        misalign;
    logic [31:0] fetch_count;

    // Surrounding pipeline: drives the controls, targets and memory data.
    modport master (
        output stall, flush, pcsrc, bpc, rpc, jpc, imem_data,
        input  imem_addr, pc, dinst, dpc4, dvalid, misalign, fetch_count
    );

    // Fetch stage itself.
    modport slave (
        input  stall, flush, pcsrc, bpc, rpc, jpc, imem_data,
        output imem_addr, pc, dinst, dpc4, dvalid, misalign, fetch_count
    );
endinterface

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
//  Module      : if_stage
//  Description : Instruction-fetch stage. It holds the PC, drives a
//                combinational instruction-memory read and selects the next
//                PC. It also loads the IF/ID register, with stall and flush
//                control from the hazard unit.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  wire logic  clock,
    input  wire logic  reset,
    if_stage_if.slave  bus
);

    localparam logic [1:0] c_SRC_SEQ = 2'b00;
    localparam logic [1:0] c_SRC_BR  = 2'b01;
    localparam logic [1:0] c_SRC_REG = 2'b10;

    logic [31:0] r_pc;
    logic [31:0] r_dinst;
    logic [31:0] r_dpc4;
    logic        r_dvalid;
    logic        r_misalign;
    logic [31:0] r_fetch_count;

    logic [31:0] w_pc4;
    logic [31:0] w_target;
    logic        w_redirect;
    logic [31:0] w_npc;
    logic        w_target_misaligned;

    // pc+4 wraps naturally at 2^32.
    assign w_pc4 = r_pc + 32'd4;

    // Next-PC selection. Redirect targets are word-aligned by dropping the
    // low bits, and a non-zero low pair is flagged for the sticky error.
    // imem_data is not used here, so there is no path from memory to PC.
    always_comb begin
        w_target = bus.jpc;
        case (bus.pcsrc)
            c_SRC_BR:  w_target = bus.bpc;
            c_SRC_REG: w_target = bus.rpc;
            default:   w_target = bus.jpc;
        endcase
        w_redirect          = (bus.pcsrc != c_SRC_SEQ);
        w_npc               = w_redirect ? {w_target[31:2], 2'b00} : w_pc4;
        w_target_misaligned = w_redirect && (w_target[1:0] != 2'b00);
    end

    // PC and IF/ID update. Reset comes first, then flush (which also wins
    // over stall so a redirect is never lost), then stall, then a normal fetch.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_dinst       <= NOP_INST;
            r_dpc4        <= 32'd0;
            r_dvalid      <= 1'b0;
            r_misalign    <= 1'b0;
            r_fetch_count <= 32'd0;
        end else if (bus.flush) begin
            r_pc     <= w_npc;
            r_dinst  <= NOP_INST;
            r_dpc4   <= w_pc4;
            r_dvalid <= 1'b0;
            if (w_target_misaligned) begin
                r_misalign <= 1'b1;
            end
        end else if (!bus.stall) begin
            r_pc          <= w_npc;
            r_dinst       <= bus.imem_data;
            r_dpc4        <= w_pc4;
            r_dvalid      <= 1'b1;
            r_fetch_count <= r_fetch_count + 32'd1;
            if (w_target_misaligned) begin
                r_misalign <= 1'b1;
            end
        end
    end

    assign bus.imem_addr   = r_pc;
    assign bus.pc          = r_pc;
    assign bus.dinst       = r_dinst;
    assign bus.dpc4        = r_dpc4;
    assign bus.dvalid      = r_dvalid;
    assign bus.misalign    = r_misalign;
    assign bus.fetch_count = r_fetch_count;

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
//  Module      : tb_if_stage
//  Description : Directed self-checking bench for if_stage. The memory model
//                returns address + 0x1000 for every fetch.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_if_stage;

    logic clock;
    logic reset;
    int   errors;
    int   checks;

    if_stage_if bus ();

    if_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INST (32'h0000_0000)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Combinational-read instruction memory.
    assign bus.imem_data = bus.imem_addr + 32'h1000;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_if(input string tag, input logic [31:0] pc, input logic [31:0] di,
                          input logic [31:0] d4, input logic dv, input logic [31:0] fc);
        chk({tag, ".pc"},     bus.pc,                pc);
        chk({tag, ".dinst"},  bus.dinst,             di);
        chk({tag, ".dpc4"},   bus.dpc4,              d4);
        chk({tag, ".dvalid"}, {31'd0, bus.dvalid},   {31'd0, dv});
        chk({tag, ".fcount"}, bus.fetch_count,       fc);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset = 1'b1;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        bus.pcsrc = 2'b00;
        bus.bpc = 32'd0;
        bus.rpc = 32'd0;
        bus.jpc = 32'd0;

        // Reset for two edges.
        step();
        step();
        chk_if("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        chk("reset.misalign", {31'd0, bus.misalign}, 32'd0);
        chk("reset.imem_addr", bus.imem_addr, 32'h0);

        // Sequential fetch.
        reset = 1'b0;
        step();
        chk_if("seq1", 32'h4, 32'h1000, 32'h4, 1'b1, 32'd1);
        chk("seq1.imem_addr", bus.imem_addr, 32'h4);
        step();
        chk_if("seq2", 32'h8, 32'h1004, 32'h8, 1'b1, 32'd2);
        step();
        chk_if("seq3", 32'hC, 32'h1008, 32'hC, 1'b1, 32'd3);

        // Jump back to 8, then branch to 0x40 with the delay slot kept.
        bus.pcsrc = 2'b11; bus.jpc = 32'h8;
        step();
        chk_if("jmp8", 32'h8, 32'h100C, 32'h10, 1'b1, 32'd4);
        bus.pcsrc = 2'b01; bus.bpc = 32'h40;
        step();
        chk_if("branch", 32'h40, 32'h1008, 32'hC, 1'b1, 32'd5);

        // Go to 16, then stall three cycles while a jump is presented.
        bus.pcsrc = 2'b11; bus.jpc = 32'h10;
        step();
        chk_if("jmp16", 32'h10, 32'h1040, 32'h44, 1'b1, 32'd6);
        bus.stall = 1'b1; bus.jpc = 32'h80;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_if("stall", 32'h10, 32'h1040, 32'h44, 1'b1, 32'd6);
        end
        bus.stall = 1'b0; bus.pcsrc = 2'b00;
        step();
        chk_if("unstall", 32'h14, 32'h1010, 32'h14, 1'b1, 32'd7);

        // Flush wins over stall; register-jump redirect taken.
        bus.stall = 1'b1; bus.flush = 1'b1; bus.pcsrc = 2'b10; bus.rpc = 32'h100;
        step();
        chk_if("flush", 32'h100, 32'h0, 32'h18, 1'b0, 32'd7);
        chk("flush.misalign", {31'd0, bus.misalign}, 32'd0);

        // A misaligned target presented during a stall is ignored.
        bus.flush = 1'b0; bus.pcsrc = 2'b11; bus.jpc = 32'h203;
        step();
        chk("stallmis.pc", bus.pc, 32'h100);
        chk("stallmis.misalign", {31'd0, bus.misalign}, 32'd0);

        // Misaligned jump taken: target aligned, sticky flag set.
        bus.stall = 1'b0;
        step();
        chk_if("mis", 32'h200, 32'h1100, 32'h104, 1'b1, 32'd8);
        chk("mis.misalign", {31'd0, bus.misalign}, 32'd1);
        bus.jpc = 32'h300;
        step();
        chk("mis2.pc", bus.pc, 32'h300);
        chk("mis2.misalign", {31'd0, bus.misalign}, 32'd1);

        // PC wrap.
        bus.jpc = 32'hFFFF_FFFC;
        step();
        chk_if("top", 32'hFFFF_FFFC, 32'h1300, 32'h304, 1'b1, 32'd10);
        bus.pcsrc = 2'b00;
        step();
        chk_if("wrap", 32'h0, 32'h0000_0FFC, 32'h0, 1'b1, 32'd11);
        chk("wrap.misalign", {31'd0, bus.misalign}, 32'd1);

        // Reset mid-run with stall, flush and a redirect pending.
        reset = 1'b1; bus.stall = 1'b1; bus.flush = 1'b1;
        bus.pcsrc = 2'b01; bus.bpc = 32'h47;
        step();
        chk_if("rst2", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        chk("rst2.misalign", {31'd0, bus.misalign}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
